// File: rtl/noc_flit_pkg.sv
// Shared flit-link definitions: widths, flit type codes and framing FSM states
// for the credit-based receive port.
package noc_flit_pkg;

  localparam int FLIT_W  = 20;
  localparam int DEPTH   = 8;
  localparam int AW      = 3;
  localparam int TYPE_HI = 19;
  localparam int TYPE_LO = 18;

  typedef enum logic [1:0] {
    FT_BODY   = 2'b00,
    FT_TAIL   = 2'b01,
    FT_HEAD   = 2'b10,
    FT_SINGLE = 2'b11
  } flit_type_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_IN_PKT = 1'b1
  } rx_state_t;

  function automatic flit_type_t flit_type(input logic [FLIT_W-1:0] flit);
    return flit_type_t'(flit[TYPE_HI:TYPE_LO]);
  endfunction

endpackage

// File: rtl/noc_credit_rx_port_if.sv
// Flit link bundle: upstream flit/valid with credit return, plus the
// downstream valid/ready drain side.
interface noc_credit_rx_port_if;
  import noc_flit_pkg::*;

  logic [FLIT_W-1:0] datain;
  logic              in_valid;
  logic              co;
  logic [FLIT_W-1:0] dataout;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output datain, in_valid, out_ready,
    input  co, dataout, out_valid
  );

  modport slave (
    input  datain, in_valid, out_ready,
    output co, dataout, out_valid
  );
endinterface

// File: rtl/noc_rx_fifo.sv
// Synchronous first-word-fall-through FIFO; the caller guarantees push only
// when not full (or popping) and pop only when non-empty.
module noc_rx_fifo
  import noc_flit_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [FLIT_W-1:0] wdata,
  output logic [FLIT_W-1:0] rdata,
  output logic              empty,
  output logic              full,
  output logic [AW:0]       count
);

  logic [FLIT_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr_reg;
  logic [AW-1:0]     rd_ptr_reg;
  logic [AW:0]       count_reg;
  logic [AW:0]       count_next;

  // Storage carries no reset; stale entries are never visible while empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= wdata;
  end

  assign count_next = count_reg + (AW+1)'(push) - (AW+1)'(pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_next;
    end
  end

  assign rdata = mem[rd_ptr_reg];
  assign empty = (count_reg == '0);
  assign full  = (count_reg == (AW+1)'(DEPTH));
  assign count = count_reg;

endmodule

// File: rtl/noc_credit_rx_port.sv
// Receive endpoint of the credit flit link: buffers flits, returns one credit
// per drained flit, and checks head/body/tail framing.
module noc_credit_rx_port
  import noc_flit_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  noc_credit_rx_port_if.slave  link,
  output logic [AW:0]          count,
  output logic                 overflow,
  output logic                 frame_err,
  output logic [15:0]          pkt_cnt
);

  logic        empty;
  logic        full;
  logic        push;
  logic        pop;
  logic        drop;
  logic        co_reg;
  logic        overflow_reg;
  logic        frame_err_reg;
  logic [15:0] pkt_cnt_reg;
  rx_state_t   state_reg;
  rx_state_t   state_next;
  logic        err_set;
  logic        pkt_inc;

  assign pop  = link.out_valid & link.out_ready;
  // A full FIFO still takes a flit when the head leaves in the same cycle.
  assign push = link.in_valid & (~full | pop);
  assign drop = link.in_valid & full & ~pop;

  noc_rx_fifo u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (link.datain),
    .rdata (link.dataout),
    .empty (empty),
    .full  (full),
    .count (count)
  );

  assign link.out_valid = ~empty;

  always_comb begin
    state_next = state_reg;
    err_set    = 1'b0;
    pkt_inc    = 1'b0;
    if (push) begin
      unique case (state_reg)
        ST_IDLE: begin
          unique case (flit_type(link.datain))
            FT_HEAD:   state_next = ST_IN_PKT;
            FT_SINGLE: pkt_inc    = 1'b1;
            default:   err_set    = 1'b1;
          endcase
        end
        ST_IN_PKT: begin
          unique case (flit_type(link.datain))
            FT_BODY: state_next = ST_IN_PKT;
            FT_TAIL: begin
              state_next = ST_IDLE;
              pkt_inc    = 1'b1;
            end
            FT_HEAD: err_set = 1'b1;
            FT_SINGLE: begin
              state_next = ST_IDLE;
              err_set    = 1'b1;
              pkt_inc    = 1'b1;
            end
          endcase
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      co_reg        <= 1'b0;
      overflow_reg  <= 1'b0;
      frame_err_reg <= 1'b0;
      pkt_cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      co_reg    <= pop;
      if (drop)    overflow_reg  <= 1'b1;
      if (err_set) frame_err_reg <= 1'b1;
      if (pkt_inc) pkt_cnt_reg   <= pkt_cnt_reg + 16'd1;
    end
  end

  assign link.co   = co_reg;
  assign overflow  = overflow_reg;
  assign frame_err = frame_err_reg;
  assign pkt_cnt   = pkt_cnt_reg;

endmodule

// File: tb/tb_noc_credit_rx_port.sv
// Bench for noc_credit_rx_port: directed scenarios then random traffic, all
// checked against a queue-based model of the receive port.
module tb_noc_credit_rx_port;
  import noc_flit_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [AW:0] count;
  logic        overflow;
  logic        frame_err;
  logic [15:0] pkt_cnt;

  noc_credit_rx_port_if link();

  noc_credit_rx_port dut (
    .clk       (clk),
    .rst       (rst),
    .link      (link),
    .count     (count),
    .overflow  (overflow),
    .frame_err (frame_err),
    .pkt_cnt   (pkt_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [FLIT_W-1:0] q[$];
  bit                m_co;
  bit                m_ovf;
  bit                m_ferr;
  bit                m_in_pkt;
  logic [15:0]       m_pkt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [FLIT_W-1:0] mk(input logic [1:0] t, input logic [17:0] p);
    return {t, p};
  endfunction

  task automatic model_clear();
    q.delete();
    m_co = 0; m_ovf = 0; m_ferr = 0; m_in_pkt = 0; m_pkt = '0;
  endtask

  // Reset is applied with live traffic on the inputs to show it overrides everything.
  task automatic do_reset();
    link.datain    = mk(2'b11, 18'h3ffff);
    link.in_valid  = 1'b1;
    link.out_ready = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
    $display("reset");
  endtask

  task automatic cycle(input logic [FLIT_W-1:0] d, input bit iv, input bit ordy);
    bit       mpop;
    bit       acc;
    logic [1:0] t;
    link.datain    = d;
    link.in_valid  = iv;
    link.out_ready = ordy;
    @(negedge clk);
    check("count", 32'(count), 32'(q.size()));
    check("out_valid", 32'(link.out_valid), 32'(q.size() != 0));
    if (q.size() != 0) check("dataout", 32'(link.dataout), 32'(q[0]));
    check("co", 32'(link.co), 32'(m_co));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("frame_err", 32'(frame_err), 32'(m_ferr));
    check("pkt_cnt", 32'(pkt_cnt), 32'(m_pkt));
    @(posedge clk);
    #1;
    mpop = (q.size() != 0) && ordy;
    acc  = iv && ((q.size() < DEPTH) || mpop);
    m_co = mpop;
    if (iv && !acc) m_ovf = 1;
    if (mpop) void'(q.pop_front());
    if (acc) begin
      q.push_back(d);
      t = d[19:18];
      if (!m_in_pkt) begin
        if (t == 2'b10) m_in_pkt = 1;
        else if (t == 2'b11) m_pkt++;
        else m_ferr = 1;
      end else begin
        case (t)
          2'b01: begin m_in_pkt = 0; m_pkt++; end
          2'b10: m_ferr = 1;
          2'b11: begin m_in_pkt = 0; m_ferr = 1; m_pkt++; end
          default: ;
        endcase
      end
    end
    if (iv || mpop)
      $display("cyc in_valid=%0d flit=%05h accepted=%0d pop=%0d occupancy=%0d pkts=%0d",
               iv, d, acc, mpop, q.size(), m_pkt);
  endtask

  initial begin
    link.datain = '0; link.in_valid = 0; link.out_ready = 0;
    model_clear();

    // Single HEAD held in the FIFO
    do_reset();
    cycle(20'h80001, 1, 0);
    cycle('0, 0, 0);
    cycle('0, 0, 0);

    // Fill to 8, drop a 9th, drain in order
    do_reset();
    for (int i = 0; i < 8; i++) cycle(mk(i == 0 ? 2'b10 : 2'b00, 18'(i + 16)), 1, 0);
    cycle(mk(2'b00, 18'h99), 1, 0);
    for (int i = 0; i < 10; i++) cycle('0, 0, 1);

    // Full with simultaneous push and pop
    do_reset();
    for (int i = 0; i < 8; i++) cycle(mk(i == 0 ? 2'b10 : 2'b00, 18'(i + 32)), 1, 0);
    cycle(mk(2'b01, 18'h77), 1, 1);
    cycle('0, 0, 0);
    for (int i = 0; i < 10; i++) cycle('0, 0, 1);

    // Clean packet stream with continuous drain
    do_reset();
    cycle(mk(2'b10, 18'h1), 1, 1);
    cycle(mk(2'b00, 18'h2), 1, 1);
    cycle(mk(2'b00, 18'h3), 1, 1);
    cycle(mk(2'b01, 18'h4), 1, 1);
    cycle(mk(2'b11, 18'h5), 1, 1);
    for (int i = 0; i < 3; i++) cycle('0, 0, 1);

    // Framing errors: BODY while idle, then HEAD HEAD, then a closing TAIL
    do_reset();
    cycle(mk(2'b00, 18'h11), 1, 1);
    cycle(mk(2'b10, 18'h12), 1, 1);
    cycle(mk(2'b10, 18'h13), 1, 1);
    cycle(mk(2'b01, 18'h14), 1, 1);
    for (int i = 0; i < 3; i++) cycle('0, 0, 1);

    // Reset mid-packet with 5 flits buffered
    do_reset();
    cycle(mk(2'b10, 18'h21), 1, 0);
    for (int i = 0; i < 4; i++) cycle(mk(2'b00, 18'(i + 34)), 1, 0);
    cycle('0, 0, 0);
    do_reset();
    cycle('0, 0, 0);
    cycle(mk(2'b11, 18'h5), 1, 1);
    cycle('0, 0, 1);
    cycle('0, 0, 1);

    // Random traffic with phases of slow and fast drain
    do_reset();
    for (int i = 0; i < 800; i++) begin
      bit iv;
      bit ordy;
      logic [1:0] t;
      if ($urandom_range(0, 299) == 0) do_reset();
      t    = 2'($urandom_range(0, 3));
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ((i / 64) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      cycle(mk(t, 18'($urandom)), iv, ordy);
    end
    for (int i = 0; i < 10; i++) cycle('0, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/noc_credit_rx_port.md
Name: noc_credit_rx_port

Overview:
Receive-side endpoint of the credit-based flit link; the counterpart of a PE transmit buffer that holds a credit counter and stalls on zero credit.
Accepts 20-bit flits, buffers them in an 8-entry FIFO, and presents them downstream with a valid/ready handshake.
Returns one credit pulse upstream per flit drained.
Checks head/body/tail framing and counts completed packets.

Parameters:
FLIT_W, 20, flit width; bits [19:18] carry the flit type.
DEPTH, 8, FIFO entries; equals the upstream credit budget.
AW, 3, log2(DEPTH).

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous active-high reset
datain  in  FLIT_W  incoming flit
in_valid  in  1  datain valid this cycle
co  out  1  credit return; one-cycle pulse per flit popped
dataout  out  FLIT_W  FIFO head (first-word fall-through)
out_valid  out  1  FIFO non-empty
out_ready  in  1  downstream accepts dataout
count  out  AW+1  current occupancy, 0..DEPTH
overflow  out  1  sticky; a flit was dropped
frame_err  out  1  sticky; framing violation seen
pkt_cnt  out  16  completed packets, wraps at 16'hFFFF->0

Behaviour:
- Reset on the rst=1 clock edge, overriding all other activity, including mid-packet and when the FIFO is non-empty:
  - count=0, co=0, overflow=0, frame_err=0, pkt_cnt=0, FSM=IDLE.
  - Pointers return to 0; dataout is don't-care while out_valid=0.
- Pop condition: pop = out_valid & out_ready.
  - The head advances on the next edge.
  - dataout/out_valid are combinational from the FIFO head and count; no added latency.
- Push condition: push = in_valid & (count<DEPTH | pop).
  - When full, a simultaneous push and pop are both accepted and count stays DEPTH.
- Drop condition: in_valid & full & !pop.
  - The flit is discarded, overflow sets, count is unchanged.
  - The FSM and pkt_cnt ignore dropped flits.
- Count update: count_next = count + push - pop.
- Pointers: wr_ptr and rd_ptr are AW bits and wrap DEPTH-1 -> 0.
- Latency: a flit written at edge N is visible on dataout after edge N (empty FIFO → out_valid=1 in cycle N+1).
- Credit return: co is registered, co <= pop.
  - Exactly one co pulse per popped flit, one cycle after the pop edge.
  - Back-to-back pops give back-to-back co highs.
- Flit types ([19:18]): 2'b10 HEAD, 2'b00 BODY, 2'b01 TAIL, 2'b11 SINGLE.
- Framing FSM advances only on accepted pushes. Every accepted flit is stored regardless of framing.
  - IDLE:
    - HEAD -> IN_PKT.
    - SINGLE -> IDLE, pkt_cnt+1.
    - BODY/TAIL -> IDLE, frame_err=1.
  - IN_PKT:
    - BODY -> IN_PKT.
    - TAIL -> IDLE, pkt_cnt+1.
    - HEAD -> IN_PKT, frame_err=1 (the new packet restarts).
    - SINGLE -> IDLE, frame_err=1, pkt_cnt+1.
- Sticky flags clear only on rst.

Decomposition:
- Package noc_flit_pkg holds FLIT_W, the type-field position, the four type codes, and the FSM state encoding.
- One sub-module: noc_rx_fifo (synchronous FWFT FIFO with push/pop/count).
- noc_credit_rx_port adds the push/drop logic, credit register, framing FSM and counters.

Test Plan:
- Reset, then 1 flit 20'h8_0001 (HEAD) with out_ready=0 -> count=1, out_valid=1, dataout=20'h80001, co stays 0.
- 8 flits with out_ready=0 -> count=8; a 9th in_valid flit -> dropped, overflow=1, count=8, FIFO contents unchanged on readout.
- FIFO full, in_valid=1 and out_ready=1 in the same cycle -> count stays 8, co=1 next cycle, new flit read back last in order.
- Stream HEAD, BODY, BODY, TAIL, then SINGLE, draining with out_ready=1 -> pkt_cnt=2, frame_err=0, exactly 5 co pulses each one cycle after its pop.
- BODY flit while IDLE; later HEAD, HEAD -> frame_err=1 after the first BODY, remains 1; FSM in IN_PKT; pkt_cnt=0.
- rst asserted mid-packet with count=5 -> next cycle count=0, out_valid=0, co=0, flags=0, pkt_cnt=0; a following SINGLE gives pkt_cnt=1 with no frame_err.
